// File: rtl/pong_game_ctrl.sv
// Frame-rate Pong sequencer: paddles, ball motion, collisions, scoring and serve/point/game-over flow.
// Optional build macro PONG_BALL_SPEEDUP_EN: each paddle hit speeds the ball up to MAX_SPEED.
module pong_game_ctrl #(
  parameter int SCREEN_W     = 640,
  parameter int SCREEN_H     = 480,
  parameter int PADDLE_W     = 8,
  parameter int PADDLE_H     = 50,
  parameter int P1_X         = 40,
  parameter int P2_X         = 600,
  parameter int BALL_SIZE    = 8,
  parameter int PADDLE_SPEED = 4,
  parameter int BALL_SPEED   = 2,
  parameter int MAX_SPEED    = 6,
  parameter int POINT_FRAMES = 60,
  parameter int WIN_SCORE    = 9
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       frame_tick,
  input  logic [5:0] btn,
  output logic [9:0] p1_y,
  output logic [9:0] p2_y,
  output logic [9:0] ball_x,
  output logic [9:0] ball_y,
  output logic [3:0] score1,
  output logic [3:0] score2,
  output logic [1:0] game_state
);

  typedef enum logic [1:0] {
    WAIT_SERVE = 2'd0,
    PLAY       = 2'd1,
    POINT      = 2'd2,
    GAME_OVER  = 2'd3
  } state_t;

  localparam int SPEED_W = $clog2(MAX_SPEED + 1);
  localparam int CNT_W   = $clog2(POINT_FRAMES);

  localparam logic [9:0]  PADDLE_MID = 10'((SCREEN_H - PADDLE_H) / 2);
  localparam logic [9:0]  BALL_MID_X = 10'((SCREEN_W - BALL_SIZE) / 2);
  localparam logic [9:0]  BALL_MID_Y = 10'((SCREEN_H - BALL_SIZE) / 2);
  localparam logic [10:0] PADDLE_MAX = 11'(SCREEN_H - PADDLE_H);
  localparam logic [10:0] PAD_STEP   = 11'(PADDLE_SPEED);
  localparam logic [10:0] PAD_H      = 11'(PADDLE_H);
  localparam logic [10:0] BALL_W     = 11'(BALL_SIZE);
  localparam logic [10:0] BALL_X_MAX = 11'(SCREEN_W - BALL_SIZE);
  localparam logic [10:0] BALL_Y_MAX = 11'(SCREEN_H - BALL_SIZE);
  localparam logic [10:0] SCR_W      = 11'(SCREEN_W);
  localparam logic [10:0] P1_FACE    = 11'(P1_X + PADDLE_W);
  localparam logic [10:0] P2_FACE    = 11'(P2_X);
  localparam logic [3:0]  WIN        = 4'(WIN_SCORE);
  localparam logic [SPEED_W-1:0] SPEED_INIT = SPEED_W'(BALL_SPEED);
  localparam logic [SPEED_W-1:0] SPEED_CAP  = SPEED_W'(MAX_SPEED);
  localparam logic [CNT_W-1:0]   CNT_LAST   = CNT_W'(POINT_FRAMES - 1);

  function automatic logic [9:0] paddle_step(input logic [9:0] y, input logic up, input logic dn);
    logic [10:0] w;
    w = {1'b0, y};
    if (up && !dn)      w = (w < PAD_STEP) ? 11'd0 : w - PAD_STEP;
    else if (dn && !up) w = (w + PAD_STEP > PADDLE_MAX) ? PADDLE_MAX : w + PAD_STEP;
    return 10'(w);
  endfunction

  function automatic logic [3:0] score_inc(input logic [3:0] s);
    return (s >= WIN) ? WIN : s + 4'd1;
  endfunction

  state_t state, state_nxt;
  logic [5:0] btn_meta, btn_sync;
  logic p1_up, p1_dn, p1_srv, p2_up, p2_dn, p2_srv;
  logic server, dy_down, serve_dy, dx_right;   // server: 0=P1, 1=P2
  logic [SPEED_W-1:0] speed;
  logic [CNT_W-1:0]   frame_cnt;

  logic [9:0] p1_y_nxt, p2_y_nxt, ball_x_nxt, ball_y_nxt;
  logic [3:0] score1_nxt, score2_nxt;
  logic server_nxt, dy_down_nxt, serve_dy_nxt, dx_right_nxt;
  logic [SPEED_W-1:0] speed_nxt;
  logic [CNT_W-1:0]   frame_cnt_nxt;

  logic [10:0] spd, bx, by;
  logic [9:0]  nx, ny;
  logic ny_down, overlap1, overlap2, hit_l, hit_r, miss_l, miss_r, serve_req, point_end;

  assign {p2_srv, p2_dn, p2_up, p1_srv, p1_dn, p1_up} = btn_sync;
  assign serve_req  = server ? p2_srv : p1_srv;
  assign point_end  = (frame_cnt == CNT_LAST);
  assign game_state = state;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      btn_meta <= '0;
      btn_sync <= '0;
    end else begin
      btn_meta <= btn;
      btn_sync <= btn_meta;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= WAIT_SERVE;
    else        state <= state_nxt;
  end

  // One PLAY step, computed every cycle from the pre-update ball and paddle positions.
  always_comb begin
    spd     = 11'(speed);
    bx      = {1'b0, ball_x};
    by      = {1'b0, ball_y};
    ny_down = dy_down;
    if (dy_down) begin
      if (by + spd > BALL_Y_MAX) begin
        ny      = 10'(BALL_Y_MAX);
        ny_down = 1'b0;
      end else begin
        ny = 10'(by + spd);
      end
    end else if (by < spd) begin
      ny      = '0;
      ny_down = 1'b1;
    end else begin
      ny = 10'(by - spd);
    end

    overlap1 = (by + BALL_W > {1'b0, p1_y}) && (by < {1'b0, p1_y} + PAD_H);
    overlap2 = (by + BALL_W > {1'b0, p2_y}) && (by < {1'b0, p2_y} + PAD_H);
    hit_l  = !dx_right && overlap1 && (bx >= P1_FACE) && (bx <= P1_FACE + spd);
    miss_l = !dx_right && !hit_l && (bx < spd);
    hit_r  = dx_right && overlap2 && (bx + BALL_W <= P2_FACE) && (bx + BALL_W + spd >= P2_FACE);
    miss_r = dx_right && !hit_r && (bx + BALL_W + spd > SCR_W);

    if (hit_l)          nx = 10'(P1_FACE);
    else if (miss_l)    nx = '0;
    else if (!dx_right) nx = 10'(bx - spd);
    else if (hit_r)     nx = 10'(P2_FACE - BALL_W);
    else if (miss_r)    nx = 10'(BALL_X_MAX);
    else                nx = 10'(bx + spd);
  end

  // NOTE: every combinational output gets a default first so no latch is inferred.
  always_comb begin
    state_nxt = state;
    if (frame_tick) begin
      case (state)
        WAIT_SERVE: if (serve_req) state_nxt = PLAY;
        PLAY:       if (miss_l || miss_r) state_nxt = POINT;
        POINT:      if (point_end) state_nxt = (score1 == WIN || score2 == WIN) ? GAME_OVER : WAIT_SERVE;
        GAME_OVER:  if (p1_srv && p2_srv) state_nxt = WAIT_SERVE;
        default:    state_nxt = WAIT_SERVE;
      endcase
    end
  end

  always_comb begin
    p1_y_nxt      = p1_y;
    p2_y_nxt      = p2_y;
    ball_x_nxt    = ball_x;
    ball_y_nxt    = ball_y;
    score1_nxt    = score1;
    score2_nxt    = score2;
    server_nxt    = server;
    dy_down_nxt   = dy_down;
    serve_dy_nxt  = serve_dy;
    dx_right_nxt  = dx_right;
    speed_nxt     = speed;
    frame_cnt_nxt = frame_cnt;
    if (frame_tick) begin
      if (state != GAME_OVER) begin
        p1_y_nxt = paddle_step(p1_y, p1_up, p1_dn);
        p2_y_nxt = paddle_step(p2_y, p2_up, p2_dn);
      end
      case (state)
        WAIT_SERVE: begin
          if (serve_req) begin
            dx_right_nxt = !server;
            dy_down_nxt  = serve_dy;
            serve_dy_nxt = !serve_dy;
          end
        end
        PLAY: begin
          ball_x_nxt  = nx;
          ball_y_nxt  = ny;
          dy_down_nxt = ny_down;
          if (hit_l || hit_r) begin
            dx_right_nxt = hit_l;
`ifdef PONG_BALL_SPEEDUP_EN
            speed_nxt = (speed >= SPEED_CAP) ? SPEED_CAP : speed + SPEED_W'(1);
`else
            speed_nxt = speed;
`endif
          end
          if (miss_l) begin
            score2_nxt = score_inc(score2);
            server_nxt = 1'b0;
          end
          if (miss_r) begin
            score1_nxt = score_inc(score1);
            server_nxt = 1'b1;
          end
        end
        POINT: begin
          if (point_end) begin
            frame_cnt_nxt = '0;
            ball_x_nxt    = BALL_MID_X;
            ball_y_nxt    = BALL_MID_Y;
            speed_nxt     = SPEED_INIT;
          end else begin
            frame_cnt_nxt = frame_cnt + CNT_W'(1);
          end
        end
        GAME_OVER: begin
          if (p1_srv && p2_srv) begin
            score1_nxt = '0;
            score2_nxt = '0;
            p1_y_nxt   = PADDLE_MID;
            p2_y_nxt   = PADDLE_MID;
            server_nxt = 1'b0;
            speed_nxt  = SPEED_INIT;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      p1_y      <= PADDLE_MID;
      p2_y      <= PADDLE_MID;
      ball_x    <= BALL_MID_X;
      ball_y    <= BALL_MID_Y;
      score1    <= '0;
      score2    <= '0;
      server    <= 1'b0;
      dy_down   <= 1'b1;
      serve_dy  <= 1'b1;
      dx_right  <= 1'b1;
      speed     <= SPEED_INIT;
      frame_cnt <= '0;
    end else begin
      p1_y      <= p1_y_nxt;
      p2_y      <= p2_y_nxt;
      ball_x    <= ball_x_nxt;
      ball_y    <= ball_y_nxt;
      score1    <= score1_nxt;
      score2    <= score2_nxt;
      server    <= server_nxt;
      dy_down   <= dy_down_nxt;
      serve_dy  <= serve_dy_nxt;
      dx_right  <= dx_right_nxt;
      speed     <= speed_nxt;
      frame_cnt <= frame_cnt_nxt;
    end
  end

endmodule

// File: tb/tb_pong_game_ctrl.sv
// Directed bench for pong_game_ctrl: paddles, serve, miss/point, paddle hit, game over and async reset.
module tb_pong_game_ctrl;

  localparam logic [5:0] P1_UP  = 6'b000001;
  localparam logic [5:0] P1_DN  = 6'b000010;
  localparam logic [5:0] P1_SRV = 6'b000100;
  localparam logic [5:0] P2_UP  = 6'b001000;
  localparam logic [5:0] P2_DN  = 6'b010000;
  localparam logic [5:0] P2_SRV = 6'b100000;
  localparam logic [5:0] PARK   = P1_DN | P2_UP;  // P1 at bottom, P2 at top

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       frame_tick = 1'b0;
  logic [5:0] btn = '0;
  logic [9:0] p1_y, p2_y, ball_x, ball_y;
  logic [3:0] score1, score2;
  logic [1:0] game_state;

  int n_checks = 0;
  int n_fail   = 0;

  pong_game_ctrl dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .frame_tick (frame_tick),
    .btn        (btn),
    .p1_y       (p1_y),
    .p2_y       (p2_y),
    .ball_x     (ball_x),
    .ball_y     (ball_y),
    .score1     (score1),
    .score2     (score2),
    .game_state (game_state)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  // Three idle cycles let btn cross the synchronizer before each tick edge.
  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      repeat (3) @(negedge clk);
      frame_tick = 1'b1;
      @(negedge clk);
      frame_tick = 1'b0;
    end
  endtask

  task automatic wait_state(input string tag, input logic [1:0] target, input int budget);
    int k;
    k = 0;
    while (game_state !== target && k < budget) begin
      tick(1);
      k++;
    end
    check(tag, 32'(game_state), 32'(target));
  endtask

  task automatic check_centre(input string tag);
    check({tag, "_bx"}, 32'(ball_x), 316);
    check({tag, "_by"}, 32'(ball_y), 236);
  endtask

  initial begin
    // Reset and idle
    #23 rst_n = 1'b1;
    check("rst_p1", 32'(p1_y), 215);
    check("rst_state", 32'(game_state), 0);
    tick(10);
    check("idle_p1", 32'(p1_y), 215);
    check("idle_p2", 32'(p2_y), 215);
    check_centre("idle");
    check("idle_state", 32'(game_state), 0);
    check("idle_s1", 32'(score1), 0);
    check("idle_s2", 32'(score2), 0);

    // Paddle motion and clamping
    btn = P1_UP;
    tick(1);
    check("p1_up1", 32'(p1_y), 211);
    btn = P1_UP | P1_DN;
    tick(5);
    check("p1_updn", 32'(p1_y), 211);
    btn = P1_UP;
    tick(99);
    check("p1_top", 32'(p1_y), 0);
    btn = PARK;
    tick(120);
    check("p1_bot", 32'(p1_y), 430);
    check("p2_top", 32'(p2_y), 0);

    // Serve handling
    btn = PARK | P2_SRV;
    tick(1);
    check("p2srv_ign", 32'(game_state), 0);
    btn = PARK | P1_SRV;
    tick(1);
    check("serve_state", 32'(game_state), 1);
    check_centre("serve");
    btn = PARK;
    tick(1);
    check("mv1_bx", 32'(ball_x), 318);
    check("mv1_by", 32'(ball_y), 238);
    repeat (2) @(negedge clk);
    check("no_tick_hold", 32'(ball_x), 318);

    // Right-side miss: P1 scores, POINT lasts 60 ticks
    tick(157);
    check("edge_bx", 32'(ball_x), 632);
    check("edge_by", 32'(ball_y), 394);
    check("edge_state", 32'(game_state), 1);
    tick(1);
    check("miss_state", 32'(game_state), 2);
    check("miss_s1", 32'(score1), 1);
    check("miss_bx", 32'(ball_x), 632);
    check("miss_by", 32'(ball_y), 392);
    tick(59);
    check("point_hold", 32'(game_state), 2);
    check("point_bx", 32'(ball_x), 632);
    tick(1);
    check("point_exit", 32'(game_state), 0);
    check_centre("point_exit");

    // P2 serves left with dy up, P1 misses
    btn = PARK | P2_SRV;
    tick(1);
    check("p2_serve", 32'(game_state), 1);
    btn = PARK;
    tick(158);
    check("left_bx", 32'(ball_x), 0);
    tick(1);
    check("lmiss_state", 32'(game_state), 2);
    check("lmiss_s2", 32'(score2), 1);
    check("lmiss_by", 32'(ball_y), 80);

    // Align P2 paddle with the ball and serve again (dy down)
    btn = P1_DN | P2_DN;
    tick(60);
    check("align_state", 32'(game_state), 0);
    check("align_p2a", 32'(p2_y), 240);
    tick(40);
    check("align_p2b", 32'(p2_y), 400);
    btn = P1_DN | P1_SRV;
    tick(1);
    btn = P1_DN;
    tick(137);
    check("pre_hit_bx", 32'(ball_x), 590);
    check("pre_hit_by", 32'(ball_y), 436);
    tick(1);
    check("hit_bx", 32'(ball_x), 592);
    check("hit_by", 32'(ball_y), 434);
    check("hit_state", 32'(game_state), 1);
    tick(1);
`ifdef PONG_BALL_SPEEDUP_EN
    check("rebound_bx", 32'(ball_x), 589);
    check("rebound_by", 32'(ball_y), 431);
`else
    check("rebound_bx", 32'(ball_x), 590);
    check("rebound_by", 32'(ball_y), 432);
`endif

    // Asynchronous reset in the middle of PLAY
    btn = '0;
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    check("arst_p1", 32'(p1_y), 215);
    check("arst_p2", 32'(p2_y), 215);
    check_centre("arst");
    check("arst_state", 32'(game_state), 0);
    check("arst_s1", 32'(score1), 0);
    check("arst_s2", 32'(score2), 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Play 17 points (alternating server) to reach 9-8 and GAME_OVER
    btn = PARK;
    tick(60);
    for (int i = 0; i < 17; i++) begin
      btn = PARK | ((i % 2 == 0) ? P1_SRV : P2_SRV);
      tick(1);
      btn = PARK;
      wait_state("game_to_point", 2'd2, 400);
      if (i % 2 == 0) check("game_s1", 32'(score1), 32'(i / 2 + 1));
      else            check("game_s2", 32'(score2), 32'(i / 2 + 1));
      wait_state("game_after_point", (i == 16) ? 2'd3 : 2'd0, 100);
    end
    check("over_s1", 32'(score1), 9);
    check("over_s2", 32'(score2), 8);
    check_centre("over");

    // Single serve ignored, paddles frozen; both serves restart
    btn = P1_SRV | P1_UP;
    tick(1);
    check("over_single", 32'(game_state), 3);
    check("over_frozen", 32'(p1_y), 430);
    btn = P1_SRV | P2_SRV;
    tick(1);
    check("restart_state", 32'(game_state), 0);
    check("restart_s1", 32'(score1), 0);
    check("restart_s2", 32'(score2), 0);
    check("restart_p1", 32'(p1_y), 215);
    check("restart_p2", 32'(p2_y), 215);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
